// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder: packs decoded RV32I fields into instruction words, queues
// them in a FIFO and drains them to an instruction-memory write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [2:0]               req_kind_i,
  input  logic [4:0]               req_rd_i,
  input  logic [4:0]               req_rs1_i,
  input  logic [4:0]               req_rs2_i,
  input  logic [2:0]               req_funct3_i,
  input  logic [6:0]               req_funct7_i,
  input  logic [31:0]              req_imm_i,
  output logic                     err_o,
  output logic                     wr_valid_o,
  input  logic                     wr_ready_i,
  output logic [31:0]              wr_addr_o,
  output logic [31:0]              wr_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [2:0] KIND_R      = 3'd0;
  localparam logic [2:0] KIND_IALU   = 3'd1;
  localparam logic [2:0] KIND_LOAD   = 3'd2;
  localparam logic [2:0] KIND_STORE  = 3'd3;
  localparam logic [2:0] KIND_BRANCH = 3'd4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [31:0]   addr_q;
  logic          err_q;

  logic [31:0] enc_word;
  logic        enc_ok;
  logic        imm12_ok;
  logic        imm13_ok;
  logic        accept;
  logic        push;
  logic        pop;

  // 12-bit immediates must sign-extend from bit 11; branch offsets from bit 12 and be even.
  assign imm12_ok = (&req_imm_i[31:11]) | ~(|req_imm_i[31:11]);
  assign imm13_ok = ((&req_imm_i[31:12]) | ~(|req_imm_i[31:12])) & ~req_imm_i[0];

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    case (req_kind_i)
      KIND_R: begin
        enc_word = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, OP_R};
        enc_ok   = 1'b1;
      end
      KIND_IALU: begin
        enc_word = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, OP_IALU};
        enc_ok   = imm12_ok;
      end
      KIND_LOAD: begin
        enc_word = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, OP_LOAD};
        enc_ok   = imm12_ok;
      end
      KIND_STORE: begin
        enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                    req_imm_i[4:0], OP_STORE};
        enc_ok   = imm12_ok;
      end
      KIND_BRANCH: begin
        enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                    req_imm_i[4:1], req_imm_i[11], OP_BRANCH};
        enc_ok   = imm13_ok;
      end
      default: begin
        enc_word = '0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  assign req_ready_o = (count_q != FULL_COUNT);
  assign wr_valid_o  = (count_q != '0);
  assign accept      = req_valid_i & req_ready_o;
  assign push        = accept & enc_ok;
  assign pop         = wr_valid_o & wr_ready_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= accept & ~enc_ok;
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
        addr_q <= addr_q + 32'd4;
      end
    end
  end

  // Storage is not reset: entries are only observable once the count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= enc_word;
    end
  end

  assign err_o     = err_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = mem_q[rptr_q];
  assign count_o   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// tb_instr_encoder: directed and randomized checks of instr_encoder against a
// field-arithmetic reference model with a queue scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_kind_i;
  logic [4:0]  req_rd_i;
  logic [4:0]  req_rs1_i;
  logic [4:0]  req_rs2_i;
  logic [2:0]  req_funct3_i;
  logic [6:0]  req_funct7_i;
  logic [31:0] req_imm_i;
  logic        err_o;
  logic        wr_valid_o;
  logic        wr_ready_i;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic [2:0]  count_o;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_kind_i   (req_kind_i),
    .req_rd_i     (req_rd_i),
    .req_rs1_i    (req_rs1_i),
    .req_rs2_i    (req_rs2_i),
    .req_funct3_i (req_funct3_i),
    .req_funct7_i (req_funct7_i),
    .req_imm_i    (req_imm_i),
    .err_o        (err_o),
    .wr_valid_o   (wr_valid_o),
    .wr_ready_i   (wr_ready_i),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_q[$];
  logic [31:0] m_addr;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference encoder: bit fields placed by shift/mask, ranges checked as signed integers.
  function automatic logic [32:0] ref_enc(input logic [31:0] kind, input logic [31:0] rd,
                                          input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [31:0] f3, input logic [31:0] f7,
                                          input logic [31:0] imm);
    int          s;
    logic [31:0] w;
    logic        ok;
    s  = $signed(imm);
    w  = 32'h0;
    ok = 1'b0;
    case (kind)
      32'd0: begin
        w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
        ok = 1'b1;
      end
      32'd1, 32'd2: begin
        w  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) |
             ((kind == 32'd1) ? 32'h13 : 32'h03);
        ok = (s >= -2048) && (s <= 2047);
      end
      32'd3: begin
        w  = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
             ((imm & 32'h1F) << 7) | 32'h23;
        ok = (s >= -2048) && (s <= 2047);
      end
      32'd4: begin
        w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
             (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) |
             (((imm >> 11) & 32'h1) << 7) | 32'h63;
        ok = (s >= -4096) && (s <= 4095) && ((s % 2) == 0);
      end
      default: begin
        w  = 32'h0;
        ok = 1'b0;
      end
    endcase
    return {ok, w};
  endfunction

  // One clock cycle: drive, compare visible state to the model, advance model, clock.
  task automatic step(input logic v, input logic [2:0] k, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic wrdy,
                      input logic rst);
    logic [32:0] e;
    logic        acc;
    rst_i = rst; req_valid_i = v; req_kind_i = k; req_rd_i = rd; req_rs1_i = rs1;
    req_rs2_i = rs2; req_funct3_i = f3; req_funct7_i = f7; req_imm_i = imm;
    wr_ready_i = wrdy;
    check("count", {29'd0, count_o}, m_q.size());
    check("ready", {31'd0, req_ready_o}, {31'd0, m_q.size() < DEPTH});
    check("wr_valid", {31'd0, wr_valid_o}, {31'd0, m_q.size() != 0});
    check("err", {31'd0, err_o}, {31'd0, m_err});
    check("addr", wr_addr_o, m_addr);
    if (m_q.size() != 0) check("data", wr_data_o, m_q[0]);
    if (rst) begin
      m_q.delete();
      m_addr = BASE_ADDR;
      m_err  = 1'b0;
    end else begin
      acc = v && (m_q.size() < DEPTH);
      e   = ref_enc({29'd0, k}, {27'd0, rd}, {27'd0, rs1}, {27'd0, rs2},
                    {29'd0, f3}, {25'd0, f7}, imm);
      if (m_q.size() != 0 && wrdy) begin
        void'(m_q.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (acc && e[32]) m_q.push_back(e[31:0]);
      m_err = acc && !e[32];
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic wrdy);
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, wrdy, 1'b0);
  endtask

  logic [31:0] rimm;

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_kind_i = 3'd0; req_rd_i = 5'd0;
    req_rs1_i = 5'd0; req_rs2_i = 5'd0; req_funct3_i = 3'd0; req_funct7_i = 7'd0;
    req_imm_i = 32'd0; wr_ready_i = 1'b0;
    m_addr = BASE_ADDR;
    m_err  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_addr", wr_addr_o, BASE_ADDR);
    check("reset_count", {29'd0, count_o}, 32'd0);

    // Known encodings from the instruction set reference.
    step(1'b1, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 1'b0);
    check("enc_ialu", wr_data_o, 32'h0050_0093);
    idle(1'b1);
    step(1'b1, 3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 1'b0);
    check("enc_store", wr_data_o, 32'h0020_A423);
    idle(1'b1);
    step(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0);
    check("enc_r", wr_data_o, 32'h0020_81B3);
    idle(1'b1);
    step(1'b1, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("enc_branch", wr_data_o, 32'hFE00_0EE3);
    idle(1'b1);
    idle(1'b1);

    // Rejected requests: one-cycle error pulse, nothing queued.
    step(1'b1, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 1'b0);
    check("err_imm_pulse", {31'd0, err_o}, 32'd1);
    check("err_imm_count", {29'd0, count_o}, 32'd0);
    step(1'b1, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1, 1'b0);
    step(1'b1, 3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 1'b0);
    idle(1'b1);
    check("err_cleared", {31'd0, err_o}, 32'd0);

    // Fill with the write side stalled, then release.
    for (int i = 0; i < 5; i++)
      step(1'b1, 3'd1, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 1'b0, 1'b0);
    check("full_count", {29'd0, count_o}, 32'd4);
    check("full_ready", {31'd0, req_ready_o}, 32'd0);
    step(1'b1, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b1, 1'b0);
    step(1'b1, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b1, 1'b0);
    repeat (6) idle(1'b1);

    // Reset while draining.
    step(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 5'd4, 5'd5, 5'd6, 3'd2, 7'd0, 32'd0, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 1'b1);
    check("rst_count", {29'd0, count_o}, 32'd0);
    check("rst_valid", {31'd0, wr_valid_o}, 32'd0);
    check("rst_addr", wr_addr_o, BASE_ADDR);

    // Randomized traffic, including boundary immediates and occasional resets.
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0:       rimm = $urandom;
        1:       rimm = 32'($signed($urandom_range(0, 8200)) - 4100);
        2:       rimm = 32'($signed($urandom_range(0, 8)) + 2043);
        default: rimm = 32'($signed($urandom_range(0, 8)) - 2052);
      endcase
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 5'($urandom),
           5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), rimm,
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end
    repeat (DEPTH + 2) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
